// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: one inverse round per clock, 10 cycles from accept to out_valid.
// Result is held in a registered output until out_ready; a new block may be loaded on the consume edge.
module aes_inv_cipher (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [1407:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];
  logic [127:0] sub_sr, ark, mixed;
  logic         load;

  for (genvar k = 0; k < 11; k++) begin : g_rk
    assign rk[k] = w[1407-128*k -: 128];
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte b of a block sits at [127-8b -: 8]; row r of column c is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++)
      o[127-8*b -: 8] = INV_SBOX[2047-8*32'(d[127-8*b -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = d[127-8*(r+4*c) -: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-8*(4*c)   -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  assign sub_sr = inv_sub_bytes(inv_shift_rows(st));
  assign ark    = sub_sr ^ rk[rnd];
  assign mixed  = inv_mix_columns(ark);
  assign load   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_nxt = BUSY;
      BUSY:    if (rnd == 4'd0) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = in_valid ? BUSY : IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= '0;
      rnd       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fsm == DONE && out_ready) out_valid <= 1'b0;
      if (load) begin
        st  <= in_data ^ rk[10];
        rnd <= 4'd9;
      end else if (fsm == BUSY) begin
        if (rnd != 4'd0) begin
          st  <= mixed;
          rnd <= rnd - 4'd1;
        end else begin
          out_data  <= ark;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using FIPS-197 vectors; key schedules come from a local key-expansion model.
module tb_aes_inv_cipher;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [1407:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;

  aes_inv_cipher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w(w), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0123456789abcdef;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_q[$];
  logic [7:0]    sbox [256];
  logic [1407:0] k1, k2;

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gxt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = gxt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box built from the GF(2^8) inverse and the affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   wk [44];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [1407:0] res = '0;
    for (int i = 0; i < 4; i++) wk[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wk[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t ^= {rcon, 24'h0};
        rcon = gxt(rcon);
      end
      wk[i] = wk[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = wk[i];
    return res;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic run_block(input string tag, input logic [1407:0] key,
                           input logic [127:0] ct, input logic [127:0] pt);
    int n;
    @(negedge clk);
    w = key; in_data = ct; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    check({tag, " latency"}, 128'(n), 128'd10);
    check({tag, " data"}, out_data, pt);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    #1 check({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sz;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; w = '0;
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    k1 = expand(KEY1);
    k2 = expand(KEY2);
    check("key10 of C.1 schedule", k1[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset out_data", out_data, 128'h0);

    run_block("C.1", k1, CT1, PT1);
    consume("C.1");
    run_block("AppB", k2, CT2, PT2);
    consume("AppB");

    // Back-pressure: result must hold and new offers must be refused.
    run_block("bp", k1, CT1, PT1);
    sz = acc_q.size();
    in_valid = 1'b1; in_data = JUNK;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp hold data", out_data, PT1);
      check("bp in_ready", 128'(in_ready), 128'd0);
      check("bp out_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    check("bp no accept", 128'(acc_q.size()), 128'(sz));
    consume("bp");

    // Back-to-back: second block accepted on the consume edge of the first.
    acc_q.delete();
    @(negedge clk);
    w = k1; in_data = CT1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(n);
    check("b2b first latency", 128'(n), 128'd10);
    check("b2b first data", out_data, PT1);
    in_data = CT2; w = k2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b first consumed", 128'(out_valid), 128'd0);
    wait_valid(n);
    check("b2b second latency", 128'(n), 128'd10);
    check("b2b second data", out_data, PT2);
    check("b2b accept count", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2) check("b2b accept spacing", 128'(acc_q[1] - acc_q[0]), 128'd11);
    @(posedge clk); #1;
    check("b2b second consumed", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    w = k1; in_data = CT1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst out_data", out_data, 128'h0);
    check("rst in_ready", 128'(in_ready), 128'd1);
    run_block("post-rst C.1", k1, CT1, PT1);
    consume("post-rst");

    // Junk offered while BUSY must be ignored.
    @(negedge clk);
    w = k2; in_data = CT2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sz = acc_q.size();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = (n >= 2 && n <= 6);
      in_data  = JUNK;
    end while (!out_valid && n < 40);
    in_valid = 1'b0;
    check("busy-ignore latency", 128'(n), 128'd10);
    check("busy-ignore data", out_data, PT2);
    check("busy-ignore no accept", 128'(acc_q.size()), 128'(sz));
    consume("busy-ignore");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core: accepts one 128-bit ciphertext block and the full expanded key schedule, and performs one inverse round per clock. After 10 rounds it presents the plaintext with a valid/ready handshake. It is the decrypt-side counterpart of the encrypt datapath. It reuses the same 1408-bit key-schedule word layout, so one key-expansion instance can feed both directions.

## Interface
Parameters:
- None; AES-128 only (Nr = 10).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext offered.
- in_ready  output  1  core can accept a block this cycle.
- in_data  input  128  ciphertext; byte 0 = [127:120], column c = bytes 4c..4c+3.
- w  input  1408  expanded key.
  - Round key k occupies w[1407-128k -: 128]: round 0 = [1407:1280], round 10 = [127:0].
  - Must be held stable from the accept edge until out_valid.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer takes plaintext this cycle.
- out_data  output  128  plaintext, same byte order as in_data.

## Operation
State machine: IDLE, BUSY, DONE. State register 128 bits; round counter 4 bits.

- **IDLE**
  - in_ready = 1.
  - On in_valid: state <= in_data ^ rk10, rnd <= 9, go to BUSY.
- **BUSY, rnd 9..1**: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]), then rnd <= rnd-1.
- **BUSY, rnd == 0**: final round without InvMixColumns.
  - out_data <= InvSubBytes(InvShiftRows(state)) ^ rk0.
  - out_valid <= 1, go to DONE.
- **DONE**
  - out_data is held stable while out_valid = 1 and out_ready = 0.
  - On out_ready: out_valid <= 0.
  - in_ready = out_ready, combinationally. If in_valid is also high, load the new block exactly as IDLE does and go to BUSY; otherwise go to IDLE.
- **InvShiftRows**: row r, meaning bytes r, r+4, r+8, r+12, is rotated right by r columns. Example: out byte 1 = in byte 13, out byte 5 = in byte 1.
- **InvSubBytes**: FIPS-197 inverse S-box applied to all 16 bytes (e.g. 63->00, 7c->01, 16->ff).
- **InvMixColumns**: per column, matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8) with reduction polynomial 0x11b.
  - Build the multiplies from xtime chains. No multiplier arrays.
- All arithmetic is XOR/GF(2^8); there is no carry and no overflow.
- in_valid during BUSY is ignored; in_ready = 0 there, and the block is not captured.
- Reset (asynchronous, any time, including mid-BUSY or DONE) forces:
  - FSM to IDLE, rnd = 0;
  - state and out_data to 128'h0;
  - out_valid = 0, in_ready = 1 after reset release;
  - any in-flight block is discarded.

## Timing
- Accept edge = rising edge with in_valid & in_ready; call it cycle 0.
- Cycles 1..9: rounds 9..1. Cycle 10: final round.
- out_valid is high after edge 10: latency is 10 cycles from accept to out_valid.
- Throughput with out_ready held high and back-to-back in_valid: one block per 11 cycles (10 compute + 1 DONE/accept overlap edge).
- Outputs are registered: out_valid, out_data. in_ready is combinational from the FSM state and out_ready.
- Critical path: one inverse round (InvShiftRows, inverse S-box, XOR, InvMixColumns) per cycle.

## Test plan
- **FIPS-197 C.1**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f expanded, in_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data = 00112233445566778899aabbccddeeff, with out_valid rising exactly 10 cycles after accept.
- **FIPS-197 Appendix B**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, in_data = 3925841d02dc09fbdc118597196a0b32.
  - Required: out_data = 3243f6a8885a308d313198a2e0370734.
- **Back-pressure**
  - Stimulus: hold out_ready = 0 for 20 cycles after out_valid.
  - Required: out_data stays constant; in_ready = 0; a new in_valid is not accepted.
  - Then release: a single-cycle out_ready drops out_valid on the next edge.
- **Back-to-back**
  - Stimulus: in_valid high continuously with the C.1 and then the Appendix B ciphertexts, out_ready = 1.
  - Required: the second block is accepted on the same edge the first is consumed; both plaintexts are correct; the accept edges are 11 cycles apart.
- **Reset mid-operation**
  - Stimulus: assert rst asynchronously in cycle 5 of BUSY.
  - Required: out_valid = 0, out_data = 0, in_ready = 1 immediately after release.
  - Then a fresh C.1 block decrypts correctly.
- **Busy-ignore**
  - Stimulus: pulse in_valid with junk data during cycles 3..7 of BUSY.
  - Required: the result is unaffected; the junk is never output.
